// File: rtl/mul_unit_if.sv
// Request/response bundle between the execute stage and the iterative multiplier.
// Execute-stage side drives operands, start, flush and setflags.
// Multiplier side returns busy, the done pulse, result and the {N,Z} flags.
interface mul_unit_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic        setflags;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [1:0]  flags;
    logic        flags_we;

    modport master (
        output start, op, a, b, c, setflags, flush,
        input  busy, done, result, flags, flags_we
    );

    modport slave (
        input  start, op, a, b, c, setflags, flush,
        output busy, done, result, flags, flags_we
    );
endinterface

// File: rtl/mul_unit.sv
// Purpose: iterative shift-add MUL/MLA/MLS, low 32 bits, plus {N,Z} flags.
// Latency: done pulses 32/BPC+1 edges after the edge that accepts start.
// Backpressure: busy is high in CALC/ACC and stalls the pipeline; start is ignored while busy.
//
// Ports: clk, reset (async, active low); bus (slave modport of mul_unit_if):
//   in : start, op (00 MUL, 01 MLA, 10 MLS, 11 as MUL), a, b, c, setflags, flush
//   out: busy, done, result, flags {N,Z}, flags_we
module mul_unit #(
    parameter int BPC = 1
) (
    input  logic        clk,
    input  logic        reset,
    mul_unit_if.slave   bus
);
    localparam int N = 32 / BPC;

    typedef enum logic [1:0] {IDLE, CALC, ACC, DONE} state_t;

    state_t      state;
    state_t      state_nx;
    logic        accept;

    logic [31:0] mcand;     // multiplicand, pre-shifted by the bits already retired
    logic [31:0] mplr;      // multiplier, consumed BPC bits per cycle from the LSB
    logic [31:0] acc_c;
    logic [1:0]  op_q;
    logic        sf_q;
    logic [5:0]  count;
    logic [31:0] prod;
    logic [31:0] partial;
    logic [31:0] res_nx;
    logic [31:0] result;
    logic [1:0]  flags;

    // Next-state logic; start is only looked at in IDLE or DONE
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (bus.start && !bus.flush) begin
                    accept   = 1'b1;
                    state_nx = CALC;
                end else begin
                    state_nx = IDLE;
                end
            end
            CALC: begin
                if (bus.flush)
                    state_nx = IDLE;
                else if (count == 6'd1)
                    state_nx = ACC;
            end
            ACC: begin
                state_nx = bus.flush ? IDLE : DONE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Sum of shifted multiplicands for the BPC multiplier bits retired this cycle
    always_comb begin
        partial = '0;
        for (int j = 0; j < BPC; j++) begin
            if (mplr[j])
                partial = partial + (mcand << j);
        end
    end

    // Final combine; everything wraps mod 2^32
    always_comb begin
        case (op_q)
            2'b01:   res_nx = acc_c + prod;
            2'b10:   res_nx = acc_c - prod;
            default: res_nx = prod;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mcand  <= '0;
            mplr   <= '0;
            acc_c  <= '0;
            op_q   <= '0;
            sf_q   <= 1'b0;
            count  <= '0;
            prod   <= '0;
            result <= '0;
            flags  <= '0;
        end else if (accept) begin
            mcand  <= bus.a;
            mplr   <= bus.b;
            acc_c  <= bus.c;
            op_q   <= bus.op;
            sf_q   <= bus.setflags;
            prod   <= '0;
            count  <= 6'(N);
        end else if (state == CALC && !bus.flush) begin
            prod   <= prod + partial;
            mcand  <= mcand << BPC;
            mplr   <= mplr >> BPC;
            count  <= count - 6'd1;
        end else if (state == ACC && !bus.flush) begin
            // A flush here leaves result/flags at their previous values
            result <= res_nx;
            flags  <= {res_nx[31], res_nx == 32'd0};
        end
    end

    assign bus.busy     = (state == CALC) || (state == ACC);
    assign bus.done     = (state == DONE);
    assign bus.flags_we = (state == DONE) && sf_q;
    assign bus.result   = result;
    assign bus.flags    = flags;
endmodule

// File: tb/tb_mul_unit.sv
// Bench for mul_unit: three instances (BPC 1, 4, 8) share operand inputs, each has its own start.
// Driver pushes hand-computed expectations into per-instance queues; negedge monitors pop on done.
module tb_mul_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start1, start4, start8;
    logic [1:0]  op;
    logic [31:0] a, b, c;
    logic        setflags, flush;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;
    int done1 = 0, done4 = 0, done8 = 0;

    typedef struct {
        logic [31:0] res;
        logic [1:0]  fl;
        logic        we;
        int          due;
    } exp_t;

    exp_t q1[$];
    exp_t q4[$];
    exp_t q8[$];

    mul_unit_if if1();
    mul_unit_if if4();
    mul_unit_if if8();

`define BIND(IFN, ST) \
    assign IFN.start = ST; \
    assign IFN.op = op; \
    assign IFN.a = a; \
    assign IFN.b = b; \
    assign IFN.c = c; \
    assign IFN.setflags = setflags; \
    assign IFN.flush = flush;

    `BIND(if1, start1)
    `BIND(if4, start4)
    `BIND(if8, start8)

    mul_unit #(.BPC(1)) u_dut1 (.clk(clk), .reset(rst_n), .bus(if1));
    mul_unit #(.BPC(4)) u_dut4 (.clk(clk), .reset(rst_n), .bus(if4));
    mul_unit #(.BPC(8)) u_dut8 (.clk(clk), .reset(rst_n), .bus(if8));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h, required %h", nm, act, exp);
    endtask

`define MON(IFN, Q, CNT, NM) \
    always @(negedge clk) begin \
        if (rst_n && IFN.done) begin \
            CNT++; \
            if (Q.size() == 0) begin \
                n_checks++; \
                $display("FAIL %s spurious_done: got done with result %h, required no done", NM, IFN.result); \
            end else begin \
                exp_t e; \
                e = Q.pop_front(); \
                chk({NM, "_result"},   IFN.result, e.res); \
                chk({NM, "_flags"},    32'(IFN.flags), 32'(e.fl)); \
                chk({NM, "_flags_we"}, 32'(IFN.flags_we), 32'(e.we)); \
                chk({NM, "_latency"},  32'(cyc), 32'(e.due)); \
            end \
        end \
    end

    `MON(if1, q1, done1, "bpc1")
    `MON(if4, q4, done4, "bpc4")
    `MON(if8, q8, done8, "bpc8")

    function automatic logic get_done(input int inst);
        case (inst)
            1:       return if1.done;
            4:       return if4.done;
            default: return if8.done;
        endcase
    endfunction

    function automatic logic get_busy(input int inst);
        case (inst)
            1:       return if1.busy;
            4:       return if4.busy;
            default: return if8.busy;
        endcase
    endfunction

    // Drives one start for one edge; expectation is queued only when push=1
    task automatic issue(input int inst, input logic [1:0] o, input logic [31:0] ai,
                         input logic [31:0] bi, input logic [31:0] ci, input logic sf,
                         input logic push, input logic [31:0] er, input logic [1:0] ef);
        exp_t e;
        op = o; a = ai; b = bi; c = ci; setflags = sf;
        case (inst)
            1:       start1 = 1'b1;
            4:       start4 = 1'b1;
            default: start8 = 1'b1;
        endcase
        @(posedge clk);
        #1;
        start1 = 1'b0; start4 = 1'b0; start8 = 1'b0;
        if (push) begin
            e.res = er; e.fl = ef; e.we = sf; e.due = cyc + 32 / inst + 1;
            case (inst)
                1:       q1.push_back(e);
                4:       q4.push_back(e);
                default: q8.push_back(e);
            endcase
        end
    endtask

    // Returns at the negedge where done is seen; counts busy cycles before it
    task automatic wait_done(input int inst, output int nbusy);
        bit seen;
        seen  = 1'b0;
        nbusy = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (get_done(inst))
                seen = 1'b1;
            else if (get_busy(inst))
                nbusy++;
        end
        if (!seen) begin
            n_checks++;
            $display("FAIL wait_done_bpc%0d: got no done in 200 cycles, required done", inst);
        end
    endtask

    initial begin
        int nb;
        int d0;
        rst_n = 1'b0;
        start1 = 1'b0; start4 = 1'b0; start8 = 1'b0;
        op = 2'b00; a = '0; b = '0; c = '0; setflags = 1'b0; flush = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy",     32'(if1.busy), 32'd0);
        chk("reset_done",     32'(if1.done), 32'd0);
        chk("reset_result",   if1.result, 32'd0);
        chk("reset_flags",    32'(if1.flags), 32'd0);
        chk("reset_flags_we", 32'(if1.flags_we), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // MUL 7*6, setflags clear
        issue(1, 2'b00, 32'd7, 32'd6, 32'd0, 1'b0, 1'b1, 32'h0000_002A, 2'b00);
        chk("mul_busy_after_accept", 32'(if1.busy), 32'd1);
        wait_done(1, nb);
        chk("mul_busy_cycles_bpc1", 32'(nb), 32'd33);

        // MLA issued in the DONE cycle: no idle gap
        issue(1, 2'b01, 32'hFFFF_FFFF, 32'd2, 32'd5, 1'b1, 1'b1, 32'h0000_0003, 2'b00);
        chk("back_to_back_busy", 32'(if1.busy), 32'd1);
        wait_done(1, nb);
        @(negedge clk);

        // MLS 10 - 3*4 = -2 -> N set
        issue(1, 2'b10, 32'd3, 32'd4, 32'd10, 1'b1, 1'b1, 32'hFFFF_FFFE, 2'b10);
        wait_done(1, nb);
        @(negedge clk);

        // 2^16 * 2^16 wraps to 0 -> Z set
        issue(1, 2'b00, 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b1, 1'b1, 32'h0000_0000, 2'b01);
        wait_done(1, nb);
        @(negedge clk);

        // Starts and operand churn while busy must not disturb 9*5
        issue(1, 2'b00, 32'd9, 32'd5, 32'd0, 1'b0, 1'b1, 32'h0000_002D, 2'b00);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start1 = 1'b1;
            a = $urandom; b = $urandom; c = $urandom;
            op = 2'($urandom_range(0, 3));
        end
        @(negedge clk);
        start1 = 1'b0;
        wait_done(1, nb);
        @(negedge clk);

        // Flush mid-CALC: back to IDLE, no done, result/flags unchanged
        issue(1, 2'b00, 32'd3, 32'd3, 32'd0, 1'b1, 1'b0, 32'd0, 2'b00);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_busy",   32'(if1.busy), 32'd0);
        chk("flush_result", if1.result, 32'h0000_002D);
        chk("flush_flags",  32'(if1.flags), 32'd0);
        d0 = done1;
        repeat (40) @(negedge clk);
        chk("flush_no_done", 32'(done1), 32'(d0));

        // Start together with flush in IDLE is refused
        flush = 1'b1; start1 = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0; start1 = 1'b0;
        chk("flush_blocks_start", 32'(if1.busy), 32'd0);
        @(negedge clk);

        // Async reset mid-CALC
        issue(1, 2'b00, 32'd7, 32'd6, 32'd0, 1'b0, 1'b0, 32'd0, 2'b00);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset_busy",   32'(if1.busy), 32'd0);
        chk("midreset_result", if1.result, 32'd0);
        chk("midreset_flags",  32'(if1.flags), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        d0 = done1;
        repeat (40) @(negedge clk);
        chk("midreset_no_done", 32'(done1), 32'(d0));

        // Wider retire rates
        issue(4, 2'b00, 32'd7, 32'd6, 32'd0, 1'b1, 1'b1, 32'h0000_002A, 2'b00);
        wait_done(4, nb);
        chk("mul_busy_cycles_bpc4", 32'(nb), 32'd9);
        @(negedge clk);
        issue(4, 2'b10, 32'd3, 32'd4, 32'd10, 1'b1, 1'b1, 32'hFFFF_FFFE, 2'b10);
        wait_done(4, nb);
        @(negedge clk);

        issue(8, 2'b00, 32'd7, 32'd6, 32'd0, 1'b1, 1'b1, 32'h0000_002A, 2'b00);
        wait_done(8, nb);
        chk("mul_busy_cycles_bpc8", 32'(nb), 32'd5);
        @(negedge clk);
        issue(8, 2'b10, 32'd3, 32'd4, 32'd10, 1'b1, 1'b1, 32'hFFFF_FFFE, 2'b10);
        wait_done(8, nb);

        repeat (3) @(negedge clk);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        chk("q4_drained", 32'(q4.size()), 32'd0);
        chk("q8_drained", 32'(q8.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
